// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control constants: JR decode key, PC-stage FSM encodings, word shift.
// Combinational constants only; no latency or backpressure.
package mips_ctrl_pkg;

   localparam logic [8:0] JR_KEY     = 9'b000001000;
   localparam int         WORD_SHIFT = 2;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } pc_state_e;

endpackage

// File: rtl/pc_target_mux.sv
// Next-PC priority select (JR > jump > branch > sequential), zero latency, no backpressure.
// PC_ALIGN_TRAP_EN: pass raw JR target and flag misalignment; otherwise force-align it.
module pc_target_mux
   import mips_ctrl_pkg::*;
(
   input  logic [31:0] pc_plus4_i,
   input  logic [2:0]  opcode_i,
   input  logic [5:0]  func_i,
   input  logic [31:0] jr_target_i,
   input  logic        jump_en_i,
   input  logic [25:0] jump_index_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_offset_i,
   output logic [31:0] pc_d_o,
   output logic        misalign_o
);

   logic        jr_sel;
   logic [31:0] jr_pc;
   logic [31:0] jump_pc;
   logic [31:0] branch_pc;

   assign jr_sel    = ({opcode_i, func_i} == JR_KEY);
   assign jump_pc   = {pc_plus4_i[31:28], jump_index_i, 2'b00};
   assign branch_pc = pc_plus4_i + (branch_offset_i << WORD_SHIFT);

`ifdef PC_ALIGN_TRAP_EN
   assign jr_pc      = jr_target_i;
   assign misalign_o = jr_sel && (jr_target_i[1:0] != 2'b00);
`else
   assign jr_pc      = jr_target_i & 32'hFFFF_FFFC;
   assign misalign_o = 1'b0;
`endif

   // The JR bus floats unless jr_sel, so it is gated out of every other path.
   always_comb begin
      pc_d_o = pc_plus4_i;
      if (jr_sel)              pc_d_o = jr_pc;
      else if (jump_en_i)      pc_d_o = jump_pc;
      else if (branch_taken_i) pc_d_o = branch_pc;
   end

endmodule

// File: rtl/pc_next_unit.sv
// PC register, BOOT/RUN/HALT FSM and retired-instruction counter; next PC visible one cycle later.
// stall/halt_req hold the PC; PC_ALIGN_TRAP_EN turns a misaligned JR into a sticky error + HALT.
module pc_next_unit
   import mips_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          COUNT_W      = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               stall,
   input  logic               halt_req,
   input  logic [2:0]         opcode,
   input  logic [5:0]         func,
   input  logic [31:0]        jr_target,
   input  logic               jump_en,
   input  logic [25:0]        jump_index,
   input  logic               branch_taken,
   input  logic [31:0]        branch_offset,
   output logic [31:0]        pc,
   output logic [31:0]        pc_plus4,
   output logic [1:0]         state,
   output logic               error,
   output logic [COUNT_W-1:0] instr_count
);

   logic [31:0]        pc_q;
   logic [31:0]        pc_d;
   logic               misalign;
   pc_state_e          state_q;
   logic               error_q;
   logic [COUNT_W-1:0] count_q;

   assign pc_plus4 = pc_q + 32'd4;

   pc_target_mux u_mux (
      .pc_plus4_i      (pc_plus4),
      .opcode_i        (opcode),
      .func_i          (func),
      .jr_target_i     (jr_target),
      .jump_en_i       (jump_en),
      .jump_index_i    (jump_index),
      .branch_taken_i  (branch_taken),
      .branch_offset_i (branch_offset),
      .pc_d_o          (pc_d),
      .misalign_o      (misalign)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q    <= RESET_VECTOR;
         state_q <= ST_BOOT;
         error_q <= 1'b0;
         count_q <= '0;
      end else begin
         case (state_q)
            ST_BOOT: state_q <= ST_RUN;
            ST_RUN: begin
               if (halt_req) begin
                  state_q <= ST_HALT;
               end else if (!stall) begin
                  // misalign is constant 0 when the trap is compiled out.
                  if (misalign) begin
                     error_q <= 1'b1;
                     state_q <= ST_HALT;
                  end else begin
                     pc_q    <= pc_d;
                     count_q <= count_q + COUNT_W'(1);
                  end
               end
            end
            ST_HALT: state_q <= ST_HALT;
            default: state_q <= ST_BOOT;
         endcase
      end
   end

   assign pc          = pc_q;
   assign state       = state_q;
   assign error       = error_q;
   assign instr_count = count_q;

endmodule
